modulo_n: RTL and testbench
===========================

MODULO_N -- requirements
Module: modulo_n

Interface
REQ-001 Parameter MOD, default 4, meaning count modulus (legal range 2..2^CNT_W).
REQ-002 Parameter CNT_W, default 2, meaning width of LD_VAL and Q; a combination with MOD > 2^CNT_W SHALL be rejected at elaboration.
REQ-003 CLK1  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low (sampled on CLK1 rising edge; 0 = reset).
REQ-005 D1  input  1  command bit 1 (MSB of command).
REQ-006 D2  input  1  command bit 0 (LSB of command).
REQ-007 LD_VAL  input  CNT_W  value applied by load command.
REQ-008 Q  output  CNT_W  registered count, always in 0..MOD-1.
REQ-009 f  output  1  registered wrap flag.
REQ-010 g  output  1  registered illegal-load error flag.

Function
REQ-011 Command {D1,D2} SHALL be sampled each rising CLK1 edge: 00 hold, 01 increment, 10 decrement, 11 load.
REQ-012 Hold: Q unchanged; f=0 next cycle.
REQ-013 Increment: Q<=Q+1 when Q<MOD-1; Q<=0 when Q==MOD-1.
REQ-014 Decrement: Q<=Q-1 when Q>0; Q<=MOD-1 when Q==0.
REQ-015 f SHALL be 1 for exactly the cycle after a wrap-around edge (increment at MOD-1 or decrement at 0), coincident with the wrapped Q value; 0 otherwise.
REQ-016 Consecutive wrapping edges (e.g. MOD=2, continuous increment) SHALL hold f=1 on every such cycle.
REQ-017 Load with LD_VAL < MOD: Q<=LD_VAL, f=0, no error.
REQ-018 Load with LD_VAL >= MOD: Q unchanged, f=0, error event raised (REQ-024/025).
REQ-019 Load with LD_VAL equal to current Q SHALL not raise f.
REQ-020 All outputs SHALL be driven directly from flops; no combinational path from inputs to outputs.
REQ-021 Command-to-output latency SHALL be exactly one CLK1 cycle.

Reset
REQ-022 RST==0 at a rising edge SHALL set Q=0, f=0, g=0, overriding any command in the same cycle.
REQ-023 Reset asserted mid-operation (any Q, pending wrap, set error) SHALL take effect at that edge; first command after RST returns to 1 acts from Q=0.

Configuration
REQ-024 Macro STICKY_ERR_EN defined: g SHALL set on the cycle after an illegal load and remain 1 until reset, regardless of later legal commands.
REQ-025 Macro STICKY_ERR_EN undefined: g SHALL be 1 only for the single cycle after each illegal load, 0 otherwise.
REQ-026 Counting, wrap and load behaviour SHALL be identical with or without STICKY_ERR_EN.

Verification (MOD=5, CNT_W=3 unless stated)
REQ-027 RST=0 for 2 cycles with cmd 01 -> Q=0, f=0, g=0 throughout; RST=1 then 5x cmd 01 -> Q=1,2,3,4,0, f=1 only with Q=0.
REQ-028 From Q=0, cmd 10 -> Q=4, f=1 for one cycle; further cmd 10 -> Q=3, f=0.
REQ-029 cmd 11 LD_VAL=3 -> Q=3, f=0, g=0; cmd 11 LD_VAL=6 -> Q stays 3, g=1; then cmd 01 -> Q=4, g=1 with STICKY_ERR_EN, g=0 without.
REQ-030 Q=4, cmd 01 with RST=0 same edge -> Q=0, f=0 (reset wins); with sticky g=1 set, RST=0 -> g=0.
REQ-031 MOD=2, CNT_W=1, continuous cmd 01 -> Q toggles 1,0,1,0, f=1 on each cycle Q=0.
REQ-032 MOD=4, CNT_W=2 (default), cmd 11 with every LD_VAL 0..3 -> Q=LD_VAL, g never set.

Source files
------------

// File: rtl/modulo_n.sv
// modulo_n: modulo-MOD up/down counter with load, wrap flag f and illegal-load flag g.
// Optional macro STICKY_ERR_EN: when defined, g latches until reset; otherwise g pulses for one cycle.
module modulo_n #(
    parameter int MOD   = 4,
    parameter int CNT_W = 2
) (
    input  logic             CLK1,
    input  logic             RST,
    input  logic             D1,
    input  logic             D2,
    input  logic [CNT_W-1:0] LD_VAL,
    output logic [CNT_W-1:0] Q,
    output logic             f,
    output logic             g
);
    // the modulus is carried one bit wider so MOD == 2^CNT_W still compares correctly
    localparam logic [CNT_W:0]   MOD_X = (CNT_W+1)'(MOD);
    localparam logic [CNT_W-1:0] MAX   = CNT_W'(MOD - 1);

    if (MOD < 2 || 64'(MOD) > (64'd1 << CNT_W)) begin : g_bad_cfg
        $error("modulo_n: MOD must lie in 2..2^CNT_W");
    end

    logic [CNT_W-1:0] q_q, q_d;
    logic             f_q, f_d, g_q, g_d, err;

    // next count, wrap and error flags from the sampled command
    always_comb begin
        q_d = q_q;
        f_d = 1'b0;
        err = 1'b0;
        case ({D1, D2})
            2'b01: begin
                q_d = (q_q == MAX) ? '0 : q_q + 1'b1;
                f_d = (q_q == MAX);
            end
            2'b10: begin
                q_d = (q_q == '0) ? MAX : q_q - 1'b1;
                f_d = (q_q == '0);
            end
            2'b11: begin
                err = ({1'b0, LD_VAL} >= MOD_X);
                q_d = err ? q_q : LD_VAL;
            end
            default: ;
        endcase
`ifdef STICKY_ERR_EN
        g_d = g_q | err;
`else
        g_d = err;
`endif
    end

    // registered state; reset overrides any command at the same edge
    always_ff @(posedge CLK1) begin
        if (!RST) begin
            q_q <= '0;
            f_q <= 1'b0;
            g_q <= 1'b0;
        end else begin
            q_q <= q_d;
            f_q <= f_d;
            g_q <= g_d;
        end
    end

    assign Q = q_q;
    assign f = f_q;
    assign g = g_q;
endmodule

// File: tb/tb_modulo_n.sv
// tb_modulo_n: scoreboard bench for modulo_n at MOD=5/CNT_W=3, MOD=2/CNT_W=1 and MOD=4/CNT_W=2.
module tb_modulo_n;
    typedef struct {
        logic [2:0] q;
        logic       f;
        logic       g;
    } exp_t;

`ifdef STICKY_ERR_EN
    localparam logic S = 1'b1;
`else
    localparam logic S = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst [3];
    logic       c1  [3];
    logic       c0  [3];
    logic [2:0] ld  [3];
    logic [2:0] q5;
    logic [0:0] q2;
    logic [1:0] q4;
    logic       f   [3];
    logic       g   [3];
    exp_t       sb  [3][$];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    modulo_n #(.MOD(5), .CNT_W(3)) u5 (.CLK1(clk), .RST(rst[0]), .D1(c1[0]), .D2(c0[0]),
        .LD_VAL(ld[0]), .Q(q5), .f(f[0]), .g(g[0]));
    modulo_n #(.MOD(2), .CNT_W(1)) u2 (.CLK1(clk), .RST(rst[1]), .D1(c1[1]), .D2(c0[1]),
        .LD_VAL(ld[1][0:0]), .Q(q2), .f(f[1]), .g(g[1]));
    modulo_n #(.MOD(4), .CNT_W(2)) u4 (.CLK1(clk), .RST(rst[2]), .D1(c1[2]), .D2(c0[2]),
        .LD_VAL(ld[2][1:0]), .Q(q4), .f(f[2]), .g(g[2]));

    task automatic step(input int k, input logic r, input logic [1:0] c, input logic [2:0] l,
                        input logic [2:0] eq, input logic ef, input logic eg);
        exp_t e;
        @(negedge clk);
        rst[k] = r;
        {c1[k], c0[k]} = c;
        ld[k] = l;
        e.q = eq;
        e.f = ef;
        e.g = eg;
        sb[k].push_back(e);
    endtask

    // monitor: every edge after a command, each DUT with a pending expectation is checked
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            if (sb[k].size() > 0) begin
                exp_t e;
                logic [2:0] aq;
                e = sb[k].pop_front();
                aq = (k == 0) ? q5 : (k == 1) ? {2'b00, q2} : {1'b0, q4};
                total++;
                if (aq !== e.q || f[k] !== e.f || g[k] !== e.g) begin
                    bad++;
                    $display("FAIL dut%0d: got Q=%0d f=%b g=%b want Q=%0d f=%b g=%b",
                             k, aq, f[k], g[k], e.q, e.f, e.g);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; c1[k] = 1'b0; c0[k] = 1'b0; ld[k] = '0;
        end
        // modulus 5: reset holds against increment, then count through wrap
        step(0, 0, 2'b01, 0, 0, 0, 0);
        step(0, 0, 2'b01, 0, 0, 0, 0);
        step(0, 1, 2'b01, 0, 1, 0, 0);
        step(0, 1, 2'b01, 0, 2, 0, 0);
        step(0, 1, 2'b01, 0, 3, 0, 0);
        step(0, 1, 2'b01, 0, 4, 0, 0);
        step(0, 1, 2'b01, 0, 0, 1, 0);
        step(0, 1, 2'b10, 0, 4, 1, 0);
        step(0, 1, 2'b10, 0, 3, 0, 0);
        step(0, 1, 2'b11, 3, 3, 0, 0);
        step(0, 1, 2'b11, 6, 3, 0, 1);
        step(0, 1, 2'b01, 0, 4, 0, S);
        step(0, 1, 2'b00, 0, 4, 0, S);
        step(0, 0, 2'b01, 0, 0, 0, 0);
        step(0, 1, 2'b11, 4, 4, 0, 0);
        step(0, 1, 2'b01, 0, 0, 1, 0);
        step(0, 1, 2'b01, 0, 1, 0, 0);
        step(0, 1, 2'b11, 7, 1, 0, 1);
        step(0, 1, 2'b10, 0, 0, 0, S);
        step(0, 1, 2'b10, 0, 4, 1, S);
        step(0, 1, 2'b00, 0, 4, 0, S);
        step(0, 1, 2'b11, 5, 4, 0, 1);
        step(0, 0, 2'b10, 0, 0, 0, 0);
        // modulus 2: back-to-back wraps keep f high on every Q=0 cycle
        step(1, 0, 2'b01, 0, 0, 0, 0);
        step(1, 1, 2'b01, 0, 1, 0, 0);
        step(1, 1, 2'b01, 0, 0, 1, 0);
        step(1, 1, 2'b01, 0, 1, 0, 0);
        step(1, 1, 2'b01, 0, 0, 1, 0);
        step(1, 1, 2'b10, 0, 1, 1, 0);
        step(1, 1, 2'b10, 0, 0, 0, 0);
        // modulus 4: every legal load value, then a full-range wrap
        step(2, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(2, 1, 2'b11, 3'(i), 3'(i), 0, 0);
        step(2, 1, 2'b11, 3, 3, 0, 0);
        step(2, 1, 2'b01, 0, 0, 1, 0);
        step(2, 1, 2'b10, 0, 3, 1, 0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (sb[k].size() != 0) begin
                bad++;
                total++;
                $display("FAIL drain dut%0d: got %0d pending want 0", k, sb[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
